// File: rtl/mskaes_32bits_inv_key_sched.sv
// Masked AES-128 inverse key schedule, one 32-bit column per cycle.
// Ports: start/sh_last_key load the round-10 key; sh_4bytes_rot_to_SB/sh_4bytes_from_SB
// talk to an external masked Sbox column of latency SB_LAT; sh_4bytes_to_AK with
// out_valid/out_ready/out_col/out_round streams round keys 10..0; busy/done report status.
// Shares of a byte are packed side by side; no share is ever recombined here.
module mskaes_32bits_inv_key_sched #(
    parameter int d      = 2,
    parameter int SB_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [128*d-1:0] sh_last_key,
    output logic [32*d-1:0]  sh_4bytes_rot_to_SB,
    input  logic [32*d-1:0]  sh_4bytes_from_SB,
    output logic [32*d-1:0]  sh_4bytes_to_AK,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_col,
    output logic [3:0]       out_round,
    output logic             busy,
    output logic             done
);

    localparam int CW  = 32 * d;
    localparam int BW  = 8 * d;
    localparam int WCW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EMIT    = 3'd2,
        XOR     = 3'd3,
        SB_SEND = 3'd4,
        SB_WAIT = 3'd5,
        SB_ADD  = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   w [4];
    logic [3:0]      rnd;
    logic [1:0]      col;
    logic [WCW-1:0]  wcnt;
    logic [7:0]      rcon;
    logic [CW-1:0]   rcon_sh;

    // rcon is public, so it only touches share 0 of byte 0
    assign rcon_sh = {{(CW-8){1'b0}}, rcon};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = EMIT;
            EMIT: begin
                if (out_ready && col == 2'd3)
                    state_nx = (rnd == 4'd0) ? IDLE : XOR;
            end
            XOR:     if (col == 2'd2) state_nx = SB_SEND;
            SB_SEND: state_nx = SB_WAIT;
            SB_WAIT: if (wcnt == WCW'(SB_LAT - 1)) state_nx = SB_ADD;
            SB_ADD:  state_nx = EMIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid       = (state == EMIT);
        busy            = (state != IDLE);
        out_col         = col;
        out_round       = rnd;
        sh_4bytes_to_AK = w[col];
        // RotWord: byte positions 0..3 carry w3 bytes 1,2,3,0
        sh_4bytes_rot_to_SB = {w[3][0 +: BW], w[3][3*BW +: BW],
                               w[3][2*BW +: BW], w[3][BW +: BW]};
    end

    // col doubles as the XOR step index: it wraps to 0 after column 3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd  <= 4'd0;
            col  <= 2'd0;
            wcnt <= '0;
            rcon <= 8'h36;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    rnd  <= 4'd10;
                    col  <= 2'd0;
                    rcon <= 8'h36;
                end
                EMIT: begin
                    if (out_ready) begin
                        col <= col + 2'd1;
                        if (col == 2'd3 && rnd == 4'd0) done <= 1'b1;
                    end
                end
                XOR:     col  <= col + 2'd1;
                SB_SEND: wcnt <= '0;
                SB_WAIT: wcnt <= wcnt + 1'b1;
                SB_ADD: begin
                    rnd  <= rnd - 4'd1;
                    col  <= 2'd0;
                    rcon <= {1'b0, rcon[7:1]} ^ (rcon[0] ? 8'h8d : 8'h00);
                end
                default: ;
            endcase
        end
    end

    // Share registers carry no reset so they never hold a key-independent value
    always_ff @(posedge clk) begin
        case (state)
            LOAD: begin
                for (int c = 0; c < 4; c++)
                    w[c] <= sh_last_key[CW*c +: CW];
            end
            XOR: begin
                case (col)
                    2'd0:    w[3] <= w[3] ^ w[2];
                    2'd1:    w[2] <= w[2] ^ w[1];
                    default: w[1] <= w[1] ^ w[0];
                endcase
            end
            SB_ADD:  w[0] <= w[0] ^ sh_4bytes_from_SB ^ rcon_sh;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mskaes_32bits_inv_key_sched.sv
// Bench for mskaes_32bits_inv_key_sched: FIPS-197 key, d=2/SB_LAT=4 and d=3/SB_LAT=6,
// model masked Sbox, backpressure, start during wait, mid-run reset.
module tb_mskaes_32bits_inv_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2047:0] sbox_t = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [127:0] k10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    logic [127:0] k9  = 128'hac7766f319fadc2128d12941575c006e;
    logic [127:0] k0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [31:0]  w_ref [44];
    logic [31:0]  kx_t;
    logic [7:0]   kx_rc;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_t[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb(v[31:24]), sb(v[23:16]), sb(v[15:8]), sb(v[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] k, input int c);
        return k[127 - 32*c -: 32];
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [7:0] rc_exp(input int i);
        case (i)
            0: return 8'h36;
            1: return 8'h1b;
            2: return 8'h80;
            3: return 8'h40;
            4: return 8'h20;
            5: return 8'h10;
            6: return 8'h08;
            7: return 8'h04;
            8: return 8'h02;
            9: return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // byte b of a column at [8*b +: 8] after recombination
    function automatic logic [31:0] recomb(input logic [127:0] v, input int d);
        logic [31:0] p;
        p = '0;
        for (int b = 0; b < 4; b++)
            for (int s = 0; s < d; s++)
                p[8*b +: 8] = p[8*b +: 8] ^ v[8*d*b + 8*s +: 8];
        return p;
    endfunction

    function automatic logic [127:0] share32(input logic [31:0] p, input int d);
        logic [127:0] v;
        logic [7:0]   acc;
        logic [7:0]   r;
        v = '0;
        for (int b = 0; b < 4; b++) begin
            acc = p[8*b +: 8];
            for (int s = 1; s < d; s++) begin
                r = 8'($urandom);
                v[8*d*b + 8*s +: 8] = r;
                acc = acc ^ r;
            end
            v[8*d*b +: 8] = acc;
        end
        return v;
    endfunction

    function automatic logic [511:0] share_key(input logic [127:0] k, input int d);
        logic [511:0] v;
        logic [7:0]   acc;
        logic [7:0]   r;
        v = '0;
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 4; b++) begin
                acc = k[127 - 8*(4*c + b) -: 8];
                for (int s = 1; s < d; s++) begin
                    r = 8'($urandom);
                    v[32*d*c + 8*d*b + 8*s +: 8] = r;
                    acc = acc ^ r;
                end
                v[32*d*c + 8*d*b +: 8] = acc;
            end
        return v;
    endfunction

    function automatic logic [127:0] msbox(input logic [127:0] v, input int d);
        logic [31:0] p;
        p = recomb(v, d);
        for (int b = 0; b < 4; b++) p[8*b +: 8] = sb(p[8*b +: 8]);
        return share32(p, d);
    endfunction

    logic         rst;
    logic         a_start, a_ready, a_valid, a_busy, a_done;
    logic [1:0]   a_col;
    logic [3:0]   a_round;
    logic [255:0] a_key;
    logic [63:0]  a_rot, a_from, a_ak;
    logic         b_start, b_ready, b_valid, b_busy, b_done;
    logic [1:0]   b_col;
    logic [3:0]   b_round;
    logic [383:0] b_key;
    logic [95:0]  b_rot, b_from, b_ak;

    mskaes_32bits_inv_key_sched #(.d(2), .SB_LAT(4)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .sh_last_key(a_key),
        .sh_4bytes_rot_to_SB(a_rot), .sh_4bytes_from_SB(a_from),
        .sh_4bytes_to_AK(a_ak), .out_valid(a_valid), .out_ready(a_ready),
        .out_col(a_col), .out_round(a_round), .busy(a_busy), .done(a_done));

    mskaes_32bits_inv_key_sched #(.d(3), .SB_LAT(6)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .sh_last_key(b_key),
        .sh_4bytes_rot_to_SB(b_rot), .sh_4bytes_from_SB(b_from),
        .sh_4bytes_to_AK(b_ak), .out_valid(b_valid), .out_ready(b_ready),
        .out_col(b_col), .out_round(b_round), .busy(b_busy), .done(b_done));

    // model masked Sbox columns: fixed latency, fresh shares every cycle
    logic [63:0] a_sb [4];
    logic [95:0] b_sb [6];
    always @(posedge clk) begin
        a_sb[0] <= 64'(msbox(128'(a_rot), 2));
        for (int i = 1; i < 4; i++) a_sb[i] <= a_sb[i-1];
        b_sb[0] <= 96'(msbox(128'(b_rot), 3));
        for (int i = 1; i < 6; i++) b_sb[i] <= b_sb[i-1];
    end
    assign a_from = a_sb[3];
    assign b_from = b_sb[5];

    logic        a_mon = 1'b0;
    logic        b_mon = 1'b0;
    int          a_ptr, a_rc_i, b_ptr;
    logic        a_stall;
    logic [63:0] a_hold;

    always @(negedge clk) begin : mon_a
        int er, ec;
        if (!a_mon) begin
            a_ptr = 0; a_rc_i = 0; a_stall = 1'b0;
        end else begin
            if (3'(u_a.state) == 3'd6) begin
                check("a_rcon", 128'(u_a.rcon), 128'(rc_exp(a_rc_i)));
                a_rc_i++;
            end
            if (a_valid) begin
                er = 10 - a_ptr / 4;
                ec = a_ptr % 4;
                if (a_ptr > 43) check("a_extra", 128'(a_ptr), 128'(43));
                else begin
                    check("a_col", 128'(a_col), 128'(ec));
                    check("a_round", 128'(a_round), 128'(er));
                    check("a_data", 128'(bswap(recomb(128'(a_ak), 2))),
                          128'(w_ref[4*er + ec]));
                    if (er == 9) check("a_rk9", 128'(bswap(recomb(128'(a_ak), 2))),
                                       128'(word_of(k9, ec)));
                    if (er == 0) check("a_rk0", 128'(bswap(recomb(128'(a_ak), 2))),
                                       128'(word_of(k0, ec)));
                end
                if (a_stall) check("a_stable", 128'(a_ak), 128'(a_hold));
                a_stall = !a_ready;
                a_hold  = a_ak;
                if (a_ready) a_ptr++;
            end else a_stall = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_b
        int er, ec;
        if (!b_mon) b_ptr = 0;
        else if (b_valid) begin
            er = 10 - b_ptr / 4;
            ec = b_ptr % 4;
            if (b_ptr > 43) check("b_extra", 128'(b_ptr), 128'(43));
            else begin
                check("b_col", 128'(b_col), 128'(ec));
                check("b_round", 128'(b_round), 128'(er));
                check("b_data", 128'(bswap(recomb(128'(b_ak), 3))),
                      128'(w_ref[4*er + ec]));
                if (er == 0) check("b_rk0", 128'(bswap(recomb(128'(b_ak), 3))),
                                   128'(word_of(k0, ec)));
            end
            if (b_ready) b_ptr++;
        end
    end

    task automatic run_a(input int exp_cyc, input bit poke,
                         input bit rst_mid, input bit rnd_rdy);
        int cyc;
        bit hit;
        hit     = 1'b0;
        a_key   = 256'(share_key(k10, 2));
        a_ready = 1'b1;
        a_mon   = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 0;
        while (!a_done && !hit && cyc < 3000) begin
            @(posedge clk); cyc++; #1;
            if (rnd_rdy) a_ready = 1'($urandom_range(0, 1));
            if (poke) a_start = (3'(u_a.state) == 3'd5);
            if (rst_mid && a_ptr == 24 && 3'(u_a.state) == 3'd3) begin
                check("pre_rst_round", 128'(a_round), 128'(5));
                rst = 1'b1; #1;
                hit = 1'b1;
                check("rst_valid", 128'(a_valid), 128'(0));
                check("rst_busy", 128'(a_busy), 128'(0));
                check("rst_done", 128'(a_done), 128'(0));
                check("rst_col", 128'(a_col), 128'(0));
                check("rst_round", 128'(a_round), 128'(0));
                check("rst_rcon", 128'(u_a.rcon), 128'(8'h36));
            end
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        if (rst_mid) begin
            check("rst_hit", 128'(hit), 128'(1));
            a_mon = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            check("a_done_seen", 128'(a_done), 128'(1));
            if (exp_cyc > 0) check("a_done_cyc", 128'(cyc), 128'(exp_cyc));
            check("a_ncols", 128'(a_ptr), 128'(44));
            check("a_nrcon", 128'(a_rc_i), 128'(10));
            check("a_busy_end", 128'(a_busy), 128'(0));
            a_mon = 1'b0;
            @(posedge clk); #1;
            check("a_done_pulse", 128'(a_done), 128'(0));
        end
    endtask

    task automatic run_b(input int exp_cyc);
        int cyc;
        b_key   = 384'(share_key(k10, 3));
        b_mon   = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 3000) begin
            @(posedge clk); cyc++; #1;
        end
        check("b_done_seen", 128'(b_done), 128'(1));
        check("b_done_cyc", 128'(cyc), 128'(exp_cyc));
        check("b_ncols", 128'(b_ptr), 128'(44));
        b_mon = 1'b0;
        @(posedge clk); #1;
        check("b_done_pulse", 128'(b_done), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) w_ref[i] = word_of(k0, i);
        kx_rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            kx_t = w_ref[i-1];
            if (i % 4 == 0) begin
                kx_t  = subw({kx_t[23:0], kx_t[31:24]}) ^ {kx_rc, 24'h0};
                kx_rc = xt(kx_rc);
            end
            w_ref[i] = w_ref[i-4] ^ kx_t;
        end

        rst = 1'b1;
        a_start = 1'b0; a_ready = 1'b1; a_key = '0;
        b_start = 1'b0; b_ready = 1'b1; b_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_valid", 128'(a_valid), 128'(0));
        check("init_busy", 128'(a_busy), 128'(0));
        check("init_done", 128'(a_done), 128'(0));
        check("init_col", 128'(a_col), 128'(0));
        check("init_round", 128'(a_round), 128'(0));
        check("init_rcon", 128'(u_a.rcon), 128'(8'h36));
        check("init_b_busy", 128'(b_busy), 128'(0));
        rst = 1'b0;

        run_a(135, 1'b0, 1'b0, 1'b0);
        run_a(135, 1'b1, 1'b0, 1'b0);
        run_a(0, 1'b0, 1'b0, 1'b1);
        run_a(0, 1'b0, 1'b1, 1'b0);
        run_a(135, 1'b0, 1'b0, 1'b0);
        run_b(155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
